// File: rtl/hazard_pkg.sv
// Shared types and defaults for the operand-hazard scoreboard.
package hazard_pkg;

  localparam int unsigned NREAD_DEF  = 2;
  localparam int unsigned NSTAGE_DEF = 3;
  localparam int unsigned CNT_W_DEF  = 2;
  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned NREG_DEF   = 32;

  // Forwarded data is carried at this width; users take the low XLEN bits.
  localparam int unsigned XLEN_MAX   = 64;

  // Register address width; a single-register file still needs one bit.
  function automatic int unsigned addr_width(input int unsigned nreg);
    return (nreg <= 1) ? 1 : $clog2(nreg);
  endfunction

  typedef struct packed {
    logic                hit;
    logic                ready;
    logic [XLEN_MAX-1:0] data;
  } fwd_sel_t;

endpackage

// File: rtl/hazard_scoreboard_fwd_sel.sv
// hazard_fwd_sel: priority match of one ID read port against the forwarding
// stages. Stage 0 is the youngest and wins over older matches.
// Only present when HAZARD_SB_FWD_EN is defined.
`ifdef HAZARD_SB_FWD_EN
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int unsigned NSTAGE = NSTAGE_DEF,
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned AW     = 5
) (
  input  logic [AW-1:0]          rd_addr_i,
  input  logic [NSTAGE-1:0]      stg_valid_i,
  input  logic [NSTAGE-1:0]      stg_we_i,
  input  logic [NSTAGE*AW-1:0]   stg_waddr_i,
  input  logic [NSTAGE*XLEN-1:0] stg_data_i,
  input  logic [NSTAGE-1:0]      stg_ready_i,
  output fwd_sel_t               sel_o
);

  // Scan oldest to youngest so the youngest matching stage is the last writer
  always_comb begin
    sel_o = '0;
    for (int unsigned k = 0; k < NSTAGE; k++) begin
      if (rd_addr_i != '0 &&
          stg_valid_i[NSTAGE-1-k] && stg_we_i[NSTAGE-1-k] &&
          stg_waddr_i[(NSTAGE-1-k)*AW +: AW] == rd_addr_i) begin
        sel_o.hit   = 1'b1;
        sel_o.ready = stg_ready_i[NSTAGE-1-k];
        sel_o.data  = XLEN_MAX'(stg_data_i[(NSTAGE-1-k)*XLEN +: XLEN]);
      end
    end
  end

endmodule
`endif

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register pending-write counters, operand forwarding
// and ID stall generation for the in-order pipeline.
// HAZARD_SB_FWD_EN enables the stage forwarding muxes; without it every read
// of a pending register stalls and operands come straight from the regfile.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter  int unsigned NREAD  = NREAD_DEF,
  parameter  int unsigned NSTAGE = NSTAGE_DEF,
  parameter  int unsigned XLEN   = XLEN_DEF,
  parameter  int unsigned NREG   = NREG_DEF,
  parameter  int unsigned CNT_W  = CNT_W_DEF,
  localparam int unsigned AW     = addr_width(NREG)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREAD*AW-1:0]    rd_addr,
  input  logic [NREAD*XLEN-1:0]  rd_raw_data,
  output logic [NREAD*XLEN-1:0]  rd_data,
  input  logic [NSTAGE-1:0]      stg_valid,
  input  logic [NSTAGE-1:0]      stg_we,
  input  logic [NSTAGE*AW-1:0]   stg_waddr,
  input  logic [NSTAGE*XLEN-1:0] stg_data,
  input  logic [NSTAGE-1:0]      stg_ready,
  input  logic                   issue_valid,
  input  logic                   issue_we,
  input  logic [AW-1:0]          issue_waddr,
  input  logic                   retire_valid,
  input  logic [AW-1:0]          retire_waddr,
  output logic                   stall,
  output logic                   sb_err
);

  // One counter per address code so any AW-bit address indexes safely;
  // slot 0 is never incremented.
  localparam int unsigned NSLOT = 1 << AW;

  logic [CNT_W-1:0] cnt_q [NSLOT];
  logic [CNT_W-1:0] cnt_d [NSLOT];
  logic             sb_err_q, sb_err_d;

  logic             issue_fire, retire_fire, same_reg, struct_stall;
  logic [NREAD-1:0] port_stall;

  assign issue_fire   = issue_valid && issue_we && (issue_waddr != '0);
  assign retire_fire  = retire_valid && (retire_waddr != '0);
  assign same_reg     = issue_fire && retire_fire && (issue_waddr == retire_waddr);
  assign struct_stall = issue_fire && (cnt_q[issue_waddr] == '1);

  // Next counter state: saturating increment on issue, checked decrement on retire
  always_comb begin
    cnt_d    = cnt_q;
    sb_err_d = sb_err_q;
    if (issue_fire && !same_reg && cnt_q[issue_waddr] != '1) begin
      cnt_d[issue_waddr] = cnt_q[issue_waddr] + 1'b1;
    end
    if (retire_fire) begin
      if (cnt_q[retire_waddr] == '0) begin
        sb_err_d = 1'b1;
      end else if (!same_reg) begin
        cnt_d[retire_waddr] = cnt_q[retire_waddr] - 1'b1;
      end
    end
  end

  // Counter and sticky-error registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NSLOT; r++) begin
        cnt_q[r] <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      sb_err_q <= sb_err_d;
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_port
    logic [AW-1:0] addr;
    logic          pend;

    assign addr = rd_addr[p*AW +: AW];
    assign pend = (addr != '0) && (cnt_q[addr] != '0);

`ifdef HAZARD_SB_FWD_EN
    fwd_sel_t sel;
    logic     unused_sel;

    hazard_fwd_sel #(
      .NSTAGE (NSTAGE),
      .XLEN   (XLEN),
      .AW     (AW)
    ) u_sel (
      .rd_addr_i   (addr),
      .stg_valid_i (stg_valid),
      .stg_we_i    (stg_we),
      .stg_waddr_i (stg_waddr),
      .stg_data_i  (stg_data),
      .stg_ready_i (stg_ready),
      .sel_o       (sel)
    );

    // A match decides the port on its own; only without one can a pending
    // producer outside the window hold ID.
    assign rd_data[p*XLEN +: XLEN] = sel.hit ? sel.data[XLEN-1:0]
                                             : rd_raw_data[p*XLEN +: XLEN];
    assign port_stall[p]           = sel.hit ? !sel.ready : pend;
    assign unused_sel              = ^sel.data;
`else
    assign rd_data[p*XLEN +: XLEN] = rd_raw_data[p*XLEN +: XLEN];
    assign port_stall[p]           = pend;
`endif
  end

`ifndef HAZARD_SB_FWD_EN
  logic unused_stg;
  assign unused_stg = ^{stg_valid, stg_we, stg_waddr, stg_data, stg_ready};
`endif

  assign stall  = (|port_stall) | struct_stall;
  assign sb_err = sb_err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard (default parameters).
// Expectations follow HAZARD_SB_FWD_EN when it is defined for the build.
module tb_hazard_scoreboard;

`ifdef HAZARD_SB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [31:0] RAW0 = 32'h1111_0000;
  localparam logic [31:0] RAW1 = 32'h2222_0000;

  logic        clk, rst;
  logic [9:0]  rd_addr;
  logic [63:0] rd_raw_data, rd_data;
  logic [2:0]  stg_valid, stg_we, stg_ready;
  logic [14:0] stg_waddr;
  logic [95:0] stg_data;
  logic        issue_valid, issue_we, retire_valid;
  logic [4:0]  issue_waddr, retire_waddr;
  logic        stall, sb_err;

  typedef struct {
    string       tag;
    logic        stall;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   nvec = 0;
  int   nmis = 0;

  hazard_scoreboard #(
    .NREAD  (2),
    .NSTAGE (3),
    .XLEN   (32),
    .NREG   (32),
    .CNT_W  (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rd_addr      (rd_addr),
    .rd_raw_data  (rd_raw_data),
    .rd_data      (rd_data),
    .stg_valid    (stg_valid),
    .stg_we       (stg_we),
    .stg_waddr    (stg_waddr),
    .stg_data     (stg_data),
    .stg_ready    (stg_ready),
    .issue_valid  (issue_valid),
    .issue_we     (issue_we),
    .issue_waddr  (issue_waddr),
    .retire_valid (retire_valid),
    .retire_waddr (retire_waddr),
    .stall        (stall),
    .sb_err       (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle();
    rst          = 1'b0;
    rd_addr      = '0;
    rd_raw_data  = {RAW1, RAW0};
    stg_valid    = '0;
    stg_we       = '0;
    stg_waddr    = '0;
    stg_data     = '0;
    stg_ready    = '0;
    issue_valid  = 1'b0;
    issue_we     = 1'b0;
    issue_waddr  = '0;
    retire_valid = 1'b0;
    retire_waddr = '0;
  endtask

  task automatic stg(input int s, input logic [4:0] a, input logic [31:0] d, input logic rdy);
    stg_valid[s]          = 1'b1;
    stg_we[s]             = 1'b1;
    stg_waddr[s*5 +: 5]   = a;
    stg_data[s*32 +: 32]  = d;
    stg_ready[s]          = rdy;
  endtask

  task automatic rd(input int p, input logic [4:0] a);
    rd_addr[p*5 +: 5] = a;
  endtask

  task automatic issue(input logic [4:0] a);
    issue_valid = 1'b1;
    issue_we    = 1'b1;
    issue_waddr = a;
  endtask

  task automatic retire(input logic [4:0] a);
    retire_valid = 1'b1;
    retire_waddr = a;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic es, ee; logic [31:0] e0, e1; exp_t e;
    for (int i = 0; i < 3; i++) begin
      idle();
      es = 1'b0; ee = 1'b0; e0 = RAW0; e1 = RAW1;
      case (i)
        0: begin rst = 1'b1; rd(0, 5'd5); rd(1, 5'd6); end
        1: retire(5'd0);
        default: begin rd(0, 5'd5); rd(1, 5'd0); end
      endcase
      exp_q.push_back('{tag: $sformatf("reset[%0d]", i), stall: es, d0: e0, d1: e1, err: ee});
      #2;
      e = exp_q.pop_front();
      nvec += 4;
      if (stall !== e.stall) begin nmis++; $display("FAIL %s stall got %0b want %0b", e.tag, stall, e.stall); end
      if (rd_data[31:0] !== e.d0) begin nmis++; $display("FAIL %s rd_data0 got %h want %h", e.tag, rd_data[31:0], e.d0); end
      if (rd_data[63:32] !== e.d1) begin nmis++; $display("FAIL %s rd_data1 got %h want %h", e.tag, rd_data[63:32], e.d1); end
      if (sb_err !== e.err) begin nmis++; $display("FAIL %s sb_err got %0b want %0b", e.tag, sb_err, e.err); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic es, ee; logic [31:0] e0, e1; exp_t e;
    for (int i = 0; i < 4; i++) begin
      idle();
      es = 1'b0; ee = 1'b0; e0 = RAW0; e1 = RAW1;
      case (i)
        0: issue(5'd5);
        1: begin stg(0, 5'd5, 32'h1234, 1'b1); rd(0, 5'd5);
                 es = !FWD; e0 = FWD ? 32'h1234 : RAW0; end
        2: begin stg(2, 5'd5, 32'h1234, 1'b1); retire(5'd5); rd(1, 5'd5);
                 es = !FWD; e1 = FWD ? 32'h1234 : RAW1; end
        default: begin rd(0, 5'd5); rd(1, 5'd5); end
      endcase
      exp_q.push_back('{tag: $sformatf("b2b[%0d]", i), stall: es, d0: e0, d1: e1, err: ee});
      #2;
      e = exp_q.pop_front();
      nvec += 4;
      if (stall !== e.stall) begin nmis++; $display("FAIL %s stall got %0b want %0b", e.tag, stall, e.stall); end
      if (rd_data[31:0] !== e.d0) begin nmis++; $display("FAIL %s rd_data0 got %h want %h", e.tag, rd_data[31:0], e.d0); end
      if (rd_data[63:32] !== e.d1) begin nmis++; $display("FAIL %s rd_data1 got %h want %h", e.tag, rd_data[63:32], e.d1); end
      if (sb_err !== e.err) begin nmis++; $display("FAIL %s sb_err got %0b want %0b", e.tag, sb_err, e.err); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    logic es, ee; logic [31:0] e0, e1; exp_t e;
    for (int i = 0; i < 5; i++) begin
      idle();
      es = 1'b0; ee = 1'b0; e0 = RAW0; e1 = RAW1;
      case (i)
        0: issue(5'd7);
        1: begin stg(0, 5'd7, 32'hBEEF, 1'b0); rd(0, 5'd7);
                 es = 1'b1; e0 = FWD ? 32'hBEEF : RAW0; end
        2: begin stg(1, 5'd7, 32'hDEAD, 1'b1); rd(0, 5'd7);
                 es = !FWD; e0 = FWD ? 32'hDEAD : RAW0; end
        3: begin stg(2, 5'd7, 32'hDEAD, 1'b1); retire(5'd7); rd(0, 5'd7);
                 es = !FWD; e0 = FWD ? 32'hDEAD : RAW0; end
        default: rd(0, 5'd7);
      endcase
      exp_q.push_back('{tag: $sformatf("load_use[%0d]", i), stall: es, d0: e0, d1: e1, err: ee});
      #2;
      e = exp_q.pop_front();
      nvec += 4;
      if (stall !== e.stall) begin nmis++; $display("FAIL %s stall got %0b want %0b", e.tag, stall, e.stall); end
      if (rd_data[31:0] !== e.d0) begin nmis++; $display("FAIL %s rd_data0 got %h want %h", e.tag, rd_data[31:0], e.d0); end
      if (rd_data[63:32] !== e.d1) begin nmis++; $display("FAIL %s rd_data1 got %h want %h", e.tag, rd_data[63:32], e.d1); end
      if (sb_err !== e.err) begin nmis++; $display("FAIL %s sb_err got %0b want %0b", e.tag, sb_err, e.err); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_multi_producer();
    logic es, ee; logic [31:0] e0, e1; exp_t e;
    for (int i = 0; i < 5; i++) begin
      idle();
      es = 1'b0; ee = 1'b0; e0 = RAW0; e1 = RAW1;
      case (i)
        0, 1: issue(5'd3);
        2: begin stg(0, 5'd3, 32'h1, 1'b1); stg(2, 5'd3, 32'h2, 1'b1); retire(5'd3);
                 rd(0, 5'd3); rd(1, 5'd3);
                 es = !FWD; e0 = FWD ? 32'h1 : RAW0; e1 = FWD ? 32'h1 : RAW1; end
        3: begin stg(0, 5'd0, 32'h55, 1'b0); stg(2, 5'd3, 32'h1, 1'b1); retire(5'd3);
                 rd(0, 5'd3); rd(1, 5'd0);
                 es = !FWD; e0 = FWD ? 32'h1 : RAW0; end
        default: rd(0, 5'd3);
      endcase
      exp_q.push_back('{tag: $sformatf("multi[%0d]", i), stall: es, d0: e0, d1: e1, err: ee});
      #2;
      e = exp_q.pop_front();
      nvec += 4;
      if (stall !== e.stall) begin nmis++; $display("FAIL %s stall got %0b want %0b", e.tag, stall, e.stall); end
      if (rd_data[31:0] !== e.d0) begin nmis++; $display("FAIL %s rd_data0 got %h want %h", e.tag, rd_data[31:0], e.d0); end
      if (rd_data[63:32] !== e.d1) begin nmis++; $display("FAIL %s rd_data1 got %h want %h", e.tag, rd_data[63:32], e.d1); end
      if (sb_err !== e.err) begin nmis++; $display("FAIL %s sb_err got %0b want %0b", e.tag, sb_err, e.err); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_out_of_window();
    logic es, ee; logic [31:0] e0, e1; exp_t e;
    for (int i = 0; i < 9; i++) begin
      idle();
      es = 1'b0; ee = 1'b0; e0 = RAW0; e1 = RAW1;
      if (i == 0) begin
        issue(5'd9);
      end else if (i <= 6) begin
        rd(1, 5'd9); es = 1'b1;
        if (i == 3) stg(1, 5'd10, 32'h77, 1'b1);
      end else if (i == 7) begin
        retire(5'd9); rd(1, 5'd9); es = 1'b1;
      end else begin
        rd(1, 5'd9);
      end
      exp_q.push_back('{tag: $sformatf("window[%0d]", i), stall: es, d0: e0, d1: e1, err: ee});
      #2;
      e = exp_q.pop_front();
      nvec += 4;
      if (stall !== e.stall) begin nmis++; $display("FAIL %s stall got %0b want %0b", e.tag, stall, e.stall); end
      if (rd_data[31:0] !== e.d0) begin nmis++; $display("FAIL %s rd_data0 got %h want %h", e.tag, rd_data[31:0], e.d0); end
      if (rd_data[63:32] !== e.d1) begin nmis++; $display("FAIL %s rd_data1 got %h want %h", e.tag, rd_data[63:32], e.d1); end
      if (sb_err !== e.err) begin nmis++; $display("FAIL %s sb_err got %0b want %0b", e.tag, sb_err, e.err); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturation();
    logic es, ee; logic [31:0] e0, e1; exp_t e;
    for (int i = 0; i < 17; i++) begin
      idle();
      es = 1'b0; ee = 1'b0; e0 = RAW0; e1 = RAW1;
      case (i)
        0, 1, 2: issue(5'd4);
        3:  begin issue(5'd4); es = 1'b1; end
        4:  begin issue(5'd4); issue_we = 1'b0; end
        5:  begin rd(0, 5'd4); es = 1'b1; end
        6:  retire(5'd4);
        7:  begin issue(5'd4); retire(5'd4); end
        8:  retire(5'd4);
        9:  begin retire(5'd4); rd(0, 5'd4); es = 1'b1; end
        10: rd(0, 5'd4);
        11: retire(5'd8);
        12: ee = 1'b1;
        13: begin issue(5'd8); ee = 1'b1; end
        14: begin rd(1, 5'd8); es = 1'b1; ee = 1'b1; end
        15: begin rst = 1'b1; rd(1, 5'd8); es = 1'b1; ee = 1'b1; end
        default: rd(1, 5'd8);
      endcase
      exp_q.push_back('{tag: $sformatf("sat[%0d]", i), stall: es, d0: e0, d1: e1, err: ee});
      #2;
      e = exp_q.pop_front();
      nvec += 4;
      if (stall !== e.stall) begin nmis++; $display("FAIL %s stall got %0b want %0b", e.tag, stall, e.stall); end
      if (rd_data[31:0] !== e.d0) begin nmis++; $display("FAIL %s rd_data0 got %h want %h", e.tag, rd_data[31:0], e.d0); end
      if (rd_data[63:32] !== e.d1) begin nmis++; $display("FAIL %s rd_data1 got %h want %h", e.tag, rd_data[63:32], e.d1); end
      if (sb_err !== e.err) begin nmis++; $display("FAIL %s sb_err got %0b want %0b", e.tag, sb_err, e.err); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    do_reset();
    test_back_to_back();
    do_reset();
    test_load_use();
    do_reset();
    test_multi_producer();
    do_reset();
    test_out_of_window();
    do_reset();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
